// File: rtl/css_mcu0_dmi_uncore_resp.sv
// DMI-mapped mailbox: a TX command FIFO toward the SoC, an RX response FIFO from it,
// plus STATUS/CTRL/FLUSH registers. Reads return registered data one edge after the access.
module css_mcu0_dmi_uncore_resp #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] CTRL_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        dmi_uncore_en,
   input  logic        dmi_uncore_wr_en,
   input  logic [6:0]  dmi_uncore_addr,
   input  logic [31:0] dmi_uncore_wdata,
   output logic [31:0] dmi_uncore_rdata,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_data,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [31:0] rsp_data,
   output logic [31:0] ctrl_out
);

   localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]  DEPTH = 5'(FIFO_DEPTH);

   localparam logic [6:0] ADDR_CMD    = 7'h50;
   localparam logic [6:0] ADDR_RSP    = 7'h51;
   localparam logic [6:0] ADDR_STATUS = 7'h52;
   localparam logic [6:0] ADDR_CTRL   = 7'h53;
   localparam logic [6:0] ADDR_FLUSH  = 7'h54;

   logic [31:0]   tx_mem [FIFO_DEPTH];
   logic [31:0]   rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [4:0]    tx_count, rx_count;
   logic          tx_ovf, rx_unf;
   logic [31:0]   ctrl;
   logic [31:0]   rd_val;

   logic wr_acc, rd_acc;
   logic tx_push, tx_pop, tx_flush, tx_ovf_set;
   logic rx_push, rx_pop, rx_flush, rx_unf_set;
   logic status_w1c;

   assign wr_acc = dmi_uncore_en & dmi_uncore_wr_en;
   assign rd_acc = dmi_uncore_en & ~dmi_uncore_wr_en;

   assign cmd_valid = (tx_count != 5'd0);
   assign rsp_ready = (rx_count < DEPTH);
   assign cmd_data  = cmd_valid ? tx_mem[tx_rd_ptr] : 32'h0;
   assign ctrl_out  = ctrl;

   // Full/empty decisions use the cycle-start counts, so a pop never frees room for a same-edge push.
   assign tx_push    = wr_acc && (dmi_uncore_addr == ADDR_CMD) && (tx_count < DEPTH);
   assign tx_ovf_set = wr_acc && (dmi_uncore_addr == ADDR_CMD) && (tx_count == DEPTH);
   assign tx_pop     = cmd_valid & cmd_ready;
   assign tx_flush   = wr_acc && (dmi_uncore_addr == ADDR_FLUSH) && dmi_uncore_wdata[0];

   assign rx_push    = rsp_valid & rsp_ready;
   assign rx_pop     = rd_acc && (dmi_uncore_addr == ADDR_RSP) && (rx_count != 5'd0);
   assign rx_unf_set = rd_acc && (dmi_uncore_addr == ADDR_RSP) && (rx_count == 5'd0);
   assign rx_flush   = wr_acc && (dmi_uncore_addr == ADDR_FLUSH) && dmi_uncore_wdata[1];

   assign status_w1c = wr_acc && (dmi_uncore_addr == ADDR_STATUS);

   // NOTE: storage arrays carry no reset; emptiness is tracked by the counts and pointers alone.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= dmi_uncore_wdata;
      if (rx_push) rx_mem[rx_wr_ptr] <= rsp_data;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else if (tx_flush) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         tx_count <= tx_count + 5'(tx_push) - 5'(tx_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else if (rx_flush) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         rx_count <= rx_count + 5'(rx_push) - 5'(rx_pop);
      end
   end

   // Sticky flags: a set in the same cycle as a write-one-to-clear keeps the flag high.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
         ctrl   <= CTRL_RESET;
      end else begin
         if (tx_ovf_set)                              tx_ovf <= 1'b1;
         else if (status_w1c && dmi_uncore_wdata[16]) tx_ovf <= 1'b0;
         if (rx_unf_set)                              rx_unf <= 1'b1;
         else if (status_w1c && dmi_uncore_wdata[17]) rx_unf <= 1'b0;
         if (wr_acc && (dmi_uncore_addr == ADDR_CTRL)) ctrl <= dmi_uncore_wdata;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves rd_val unassigned.
      rd_val = 32'h0;
      unique case (dmi_uncore_addr)
         ADDR_RSP:    rd_val = (rx_count != 5'd0) ? rx_mem[rx_rd_ptr] : 32'h0;
         ADDR_STATUS: rd_val = {14'h0, rx_unf, tx_ovf, 3'h0, rx_count, 3'h0, tx_count};
         ADDR_CTRL:   rd_val = ctrl;
         default:     rd_val = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)      dmi_uncore_rdata <= 32'h0;
      else if (rd_acc) dmi_uncore_rdata <= rd_val;
   end

endmodule

// File: tb/tb_css_mcu0_dmi_uncore_resp.sv
// Bench for css_mcu0_dmi_uncore_resp: queue-based mailbox model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_css_mcu0_dmi_uncore_resp;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        dmi_uncore_en, dmi_uncore_wr_en;
   logic [6:0]  dmi_uncore_addr;
   logic [31:0] dmi_uncore_wdata, dmi_uncore_rdata;
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [31:0] cmd_data, rsp_data, ctrl_out;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   css_mcu0_dmi_uncore_resp #(.FIFO_DEPTH(DEPTH), .CTRL_RESET(32'h0)) dut (
      .clk(clk), .rst_l(rst_l),
      .dmi_uncore_en(dmi_uncore_en), .dmi_uncore_wr_en(dmi_uncore_wr_en),
      .dmi_uncore_addr(dmi_uncore_addr), .dmi_uncore_wdata(dmi_uncore_wdata),
      .dmi_uncore_rdata(dmi_uncore_rdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ctrl_out(ctrl_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mailbox contents as queues, updated once per edge from cycle-start state.
   logic [31:0] m_tx[$];
   logic [31:0] m_rx[$];
   bit          m_ovf, m_unf;
   logic [31:0] m_ctrl, m_rdata;

   always @(posedge clk or negedge rst_l) begin : model
      int          tn, rn;
      logic [31:0] rv;
      if (!rst_l) begin
         m_tx.delete();
         m_rx.delete();
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_ctrl  = 32'h0;
         m_rdata = 32'h0;
      end else begin
         tn = m_tx.size();
         rn = m_rx.size();
         if (tn != 0 && cmd_ready) void'(m_tx.pop_front());
         if (dmi_uncore_en && !dmi_uncore_wr_en) begin
            rv = 32'h0;
            case (dmi_uncore_addr)
               7'h51: if (rn > 0) rv = m_rx.pop_front(); else m_unf = 1'b1;
               7'h52: rv = {14'h0, m_unf, m_ovf, 3'h0, 5'(rn), 3'h0, 5'(tn)};
               7'h53: rv = m_ctrl;
               default: rv = 32'h0;
            endcase
            m_rdata = rv;
         end
         if (rsp_valid && rn < DEPTH) m_rx.push_back(rsp_data);
         if (dmi_uncore_en && dmi_uncore_wr_en) begin
            case (dmi_uncore_addr)
               7'h50: if (tn < DEPTH) m_tx.push_back(dmi_uncore_wdata); else m_ovf = 1'b1;
               7'h52: begin
                  if (dmi_uncore_wdata[16]) m_ovf = 1'b0;
                  if (dmi_uncore_wdata[17]) m_unf = 1'b0;
               end
               7'h53: m_ctrl = dmi_uncore_wdata;
               7'h54: begin
                  if (dmi_uncore_wdata[0]) m_tx.delete();
                  if (dmi_uncore_wdata[1]) m_rx.delete();
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (rst_l && cmp_en) begin
         check("cmp_cmd_valid", 32'(cmd_valid), 32'(m_tx.size() != 0));
         check("cmp_cmd_data", cmd_data, (m_tx.size() != 0) ? m_tx[0] : 32'h0);
         check("cmp_rsp_ready", 32'(rsp_ready), 32'(m_rx.size() < DEPTH));
         check("cmp_ctrl_out", ctrl_out, m_ctrl);
         check("cmp_rdata", dmi_uncore_rdata, m_rdata);
      end
   end

   // Tasks are entered and left at one time unit after a rising edge.
   task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
      dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b1; dmi_uncore_addr = a; dmi_uncore_wdata = d;
      @(posedge clk); #1;
      dmi_uncore_en = 1'b0; dmi_uncore_wr_en = 1'b0;
   endtask

   task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
      dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b0; dmi_uncore_addr = a;
      @(posedge clk); #1;
      dmi_uncore_en = 1'b0;
      d = dmi_uncore_rdata;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdata"}, dmi_uncore_rdata, 32'h0);
      check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'h0);
      check({tag, "_cmd_data"}, cmd_data, 32'h0);
      check({tag, "_rsp_ready"}, 32'(rsp_ready), 32'h1);
      check({tag, "_ctrl_out"}, ctrl_out, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      rst_l = 1'b0;
      dmi_uncore_en = 1'b0; dmi_uncore_wr_en = 1'b0; dmi_uncore_addr = '0; dmi_uncore_wdata = '0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      step(3);
      check_reset_outputs("reset");
      rst_l = 1'b1;
      cmp_en = 1'b1;
      step(1);

      // TX overflow then ordered drain
      for (int i = 0; i < 5; i++) dmi_write(7'h50, 32'hA1 + 32'(i));
      dmi_read(7'h52, d);
      check("status_tx_ovf", d, 32'h0001_0004);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("tx_order", cmd_data, 32'hA1 + 32'(i));
      end
      @(negedge clk);
      check("tx_drained_valid", 32'(cmd_valid), 32'h0);
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      dmi_write(7'h52, 32'h0001_0000);
      dmi_read(7'h52, d);
      check("status_ovf_cleared", d, 32'h0);

      // RX reads and underflow
      rsp_valid = 1'b1; rsp_data = 32'h11;
      step(1);
      rsp_data = 32'h22;
      step(1);
      rsp_valid = 1'b0;
      dmi_read(7'h51, d); check("rx_read0", d, 32'h11);
      dmi_read(7'h51, d); check("rx_read1", d, 32'h22);
      dmi_read(7'h51, d); check("rx_read_empty", d, 32'h0);
      dmi_read(7'h52, d); check("status_rx_unf", d, 32'h0002_0000);
      dmi_write(7'h52, 32'h0002_0000);
      dmi_read(7'h52, d); check("status_unf_cleared", d, 32'h0);

      // RX full: a same-cycle DMI pop does not open room for the push
      rsp_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rsp_data = 32'h30 + 32'(i);
         step(1);
      end
      rsp_data = 32'h55;
      dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b0; dmi_uncore_addr = 7'h51;
      @(negedge clk);
      check("rx_full_not_ready", 32'(rsp_ready), 32'h0);
      @(posedge clk); #1;
      dmi_uncore_en = 1'b0;
      check("rx_full_pop", dmi_uncore_rdata, 32'h30);
      @(negedge clk);
      check("rx_room_ready", 32'(rsp_ready), 32'h1);
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      dmi_read(7'h52, d); check("status_rx_count4", d, 32'h0000_0400);
      dmi_read(7'h51, d); check("rx_drain0", d, 32'h31);
      dmi_read(7'h51, d); check("rx_drain1", d, 32'h32);
      dmi_read(7'h51, d); check("rx_drain2", d, 32'h33);
      dmi_read(7'h51, d); check("rx_drain3", d, 32'h55);

      // CTRL, unmapped address, and en-low immunity
      dmi_write(7'h53, 32'hDEAD_BEEF);
      check("ctrl_out_after_write", ctrl_out, 32'hDEAD_BEEF);
      dmi_read(7'h53, d); check("ctrl_read", d, 32'hDEAD_BEEF);
      dmi_read(7'h60, d); check("unmapped_read", d, 32'h0);
      dmi_write(7'h60, 32'hFFFF_FFFF);
      dmi_read(7'h52, d); check("unmapped_write_no_effect", d, 32'h0);
      dmi_uncore_wr_en = 1'b1; dmi_uncore_addr = 7'h53; dmi_uncore_wdata = 32'h0;
      step(2);
      dmi_uncore_wr_en = 1'b0;
      check("en_low_ctrl_kept", ctrl_out, 32'hDEAD_BEEF);

      // TX flush beats a same-cycle handshake
      for (int i = 0; i < 3; i++) dmi_write(7'h50, 32'hC1 + 32'(i));
      cmd_ready = 1'b1;
      dmi_write(7'h54, 32'h1);
      check("tx_flush_valid", 32'(cmd_valid), 32'h0);
      cmd_ready = 1'b0;
      dmi_read(7'h52, d); check("tx_flush_status", d, 32'h0);

      // TX simultaneous push and pop keeps count and order
      dmi_write(7'h50, 32'hD1);
      dmi_write(7'h50, 32'hD2);
      cmd_ready = 1'b1;
      dmi_write(7'h50, 32'hD3);
      cmd_ready = 1'b0;
      check("tx_pushpop_head", cmd_data, 32'hD2);
      dmi_read(7'h52, d); check("tx_pushpop_count", d, 32'h0000_0002);

      // RX flush discards a same-cycle push
      rsp_valid = 1'b1; rsp_data = 32'h77;
      step(1);
      rsp_data = 32'h88;
      dmi_write(7'h54, 32'h2);
      rsp_valid = 1'b0;
      dmi_read(7'h52, d); check("rx_flush_status", d, 32'h0000_0002);
      dmi_read(7'h51, d); check("rx_flush_empty_read", d, 32'h0);
      dmi_write(7'h52, 32'h0002_0000);

      // Asynchronous reset mid-stream
      dmi_write(7'h53, 32'h1234_5678);
      dmi_write(7'h50, 32'hE1);
      rsp_valid = 1'b1; rsp_data = 32'h99;
      step(2);
      rsp_valid = 1'b0;
      dmi_read(7'h53, d);
      #3;
      rst_l = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk); #1;
      rst_l = 1'b1;
      dmi_read(7'h52, d); check("post_reset_status", d, 32'h0);
      dmi_read(7'h51, d); check("post_reset_rx_read", d, 32'h0);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
